// File: rtl/snn_pkg.sv
`default_nettype none
// ==================================================================
// snn_pkg : FSM encoding and saturating add shared by the SNN core
// Rev 1.0
// ==================================================================
package snn_pkg;

  localparam int c_SAT_W = 32;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EVAL  = 1'b1
  } state_e;

  // Operands arrive sign-extended from w bits, so the wide sum never wraps before clamping.
  function automatic logic signed [c_SAT_W-1:0] sat_add(
    input logic signed [c_SAT_W-1:0] a,
    input logic signed [c_SAT_W-1:0] b,
    input int unsigned               w
  );
    logic signed [c_SAT_W-1:0] sum;
    logic signed [c_SAT_W-1:0] hi;
    logic signed [c_SAT_W-1:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_potential_accumulator_if.sv
`default_nettype none
// ==================================================================
// neuron_potential_accumulator_if : weight-input valid/ready channel
// Rev 1.0
// ==================================================================
interface neuron_potential_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 2
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [ID_W-1:0]          in_neuron_id;
  logic signed [DATA_W-1:0] in_weight;

  modport master (output in_valid, output in_neuron_id, output in_weight, input in_ready);
  modport slave  (input in_valid, input in_neuron_id, input in_weight, output in_ready);

endinterface
`default_nettype wire

// File: rtl/neuron_update.sv
`default_nettype none
// ==================================================================
// neuron_update : one neuron's leak / fire / reset / refractory step
// Rev 1.0
// ==================================================================
module neuron_update
  import snn_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int LEAK_SHIFT     = 2,
  parameter int REFRACT_CYCLES = 2,
  parameter int RESET_MODE     = 0,
  parameter int REF_W          = 2
) (
  input  wire logic signed [DATA_W-1:0] i_pot,
  input  wire logic signed [DATA_W-1:0] i_thr,
  input  wire logic [REF_W-1:0]         i_ref,
  output logic signed [DATA_W-1:0]      o_pot,
  output logic [REF_W-1:0]              o_ref,
  output logic                          o_spike
);

  always_comb begin
    o_pot   = i_pot - (i_pot >>> LEAK_SHIFT);
    o_ref   = i_ref;
    o_spike = 1'b0;
    if (i_ref != '0) begin
      o_ref = i_ref - REF_W'(1);
      o_pot = '0;
    end else if (i_pot >= i_thr) begin
      o_spike = 1'b1;
      o_ref   = REF_W'(REFRACT_CYCLES);
      o_pot   = (RESET_MODE == 0) ? '0
              : DATA_W'(sat_add(c_SAT_W'(i_pot), -c_SAT_W'(i_thr), DATA_W));
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_potential_accumulator.sv
`default_nettype none
// ==================================================================
// neuron_potential_accumulator : integrate weights, evaluate neurons serially per timestep
// Rev 1.0
// ==================================================================
module neuron_potential_accumulator
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS    = 4,
  parameter int DATA_W         = 16,
  parameter int FRAC_W         = 8,
  parameter int LEAK_SHIFT     = 2,
  parameter int REFRACT_CYCLES = 2,
  parameter int RESET_MODE     = 0
) (
  input  wire logic                               CLK,
  input  wire logic                               RESETN,
  input  wire logic                               clear,
  input  wire logic signed [DATA_W-1:0]           v_threshold,
  neuron_potential_accumulator_if.slave           in_if,
  input  wire logic                               timestep_end,
  output logic                                    spike_valid,
  output logic [NUM_NEURONS-1:0]                  spike_vector,
  output logic                                    err_overrun,
  input  wire logic [$clog2(NUM_NEURONS)-1:0]     rd_id,
  output logic signed [DATA_W-1:0]                rd_potential
);

  localparam int c_ID_W  = $clog2(NUM_NEURONS);
  localparam int c_REF_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [c_ID_W-1:0] c_LAST = c_ID_W'(NUM_NEURONS - 1);

  if (NUM_NEURONS < 2 || DATA_W > c_SAT_W - 1 || FRAC_W >= DATA_W) begin : g_bad_params
    $error("neuron_potential_accumulator: unsupported parameter set");
  end

  state_e                   r_state, w_state_nxt;
  logic                     w_eval, w_last, w_overrun;
  logic [c_ID_W-1:0]        r_idx;
  logic signed [DATA_W-1:0] r_pot [NUM_NEURONS];
  logic [c_REF_W-1:0]       r_ref [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]   r_spike_work, r_spike_vec, w_spike_all;
  logic                     r_spike_valid, r_err;

  logic                     w_in_ok, w_rd_ok, w_acc_we;
  logic signed [DATA_W-1:0] w_acc_cur, w_acc_sum;
  logic [c_REF_W-1:0]       w_acc_ref;
  logic signed [DATA_W-1:0] w_nu_pot;
  logic [c_REF_W-1:0]       w_nu_ref;
  logic                     w_nu_spike;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_ACCUM;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    in_if.in_ready  = 1'b0;
    w_eval          = 1'b0;
    w_last          = 1'b0;
    w_overrun       = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_if.in_ready = 1'b1;
        if (timestep_end) w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        w_eval    = 1'b1;
        w_overrun = timestep_end;
        if (r_idx == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
    if (clear) w_state_nxt = ST_ACCUM;
  end

  // Ids past NUM_NEURONS (non power-of-two sizes) are consumed but never written.
  assign w_in_ok   = ({1'b0, in_if.in_neuron_id} < (c_ID_W + 1)'(NUM_NEURONS));
  assign w_rd_ok   = ({1'b0, rd_id} < (c_ID_W + 1)'(NUM_NEURONS));
  assign w_acc_cur = w_in_ok ? r_pot[in_if.in_neuron_id] : '0;
  assign w_acc_ref = w_in_ok ? r_ref[in_if.in_neuron_id] : '0;
  assign w_acc_we  = in_if.in_valid & in_if.in_ready & w_in_ok & (w_acc_ref == '0);
  assign w_acc_sum = DATA_W'(sat_add(c_SAT_W'(w_acc_cur), c_SAT_W'(in_if.in_weight), DATA_W));

  neuron_update #(
    .DATA_W         (DATA_W),
    .LEAK_SHIFT     (LEAK_SHIFT),
    .REFRACT_CYCLES (REFRACT_CYCLES),
    .RESET_MODE     (RESET_MODE),
    .REF_W          (c_REF_W)
  ) u_update (
    .i_pot   (r_pot[r_idx]),
    .i_thr   (v_threshold),
    .i_ref   (r_ref[r_idx]),
    .o_pot   (w_nu_pot),
    .o_ref   (w_nu_ref),
    .o_spike (w_nu_spike)
  );

  assign w_spike_all = r_spike_work | (NUM_NEURONS'(w_nu_spike) << r_idx);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_pot[i] <= '0;
        r_ref[i] <= '0;
      end
      r_idx         <= '0;
      r_spike_work  <= '0;
      r_spike_vec   <= '0;
      r_spike_valid <= 1'b0;
      r_err         <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_pot[i] <= '0;
        r_ref[i] <= '0;
      end
      r_idx         <= '0;
      r_spike_work  <= '0;
      r_spike_vec   <= '0;
      r_spike_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_spike_valid <= w_last;
      r_err         <= w_overrun;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_acc_we && in_if.in_neuron_id == c_ID_W'(i)) r_pot[i] <= w_acc_sum;
        if (w_eval && r_idx == c_ID_W'(i)) begin
          r_pot[i] <= w_nu_pot;
          r_ref[i] <= w_nu_ref;
        end
      end
      if (w_eval) begin
        if (w_last) begin
          r_idx        <= '0;
          r_spike_vec  <= w_spike_all;
          r_spike_work <= '0;
        end else begin
          r_idx        <= r_idx + c_ID_W'(1);
          r_spike_work <= w_spike_all;
        end
      end
    end
  end

  assign spike_valid  = r_spike_valid;
  assign spike_vector = r_spike_vec;
  assign err_overrun  = r_err;
  assign rd_potential = w_rd_ok ? r_pot[rd_id] : '0;

endmodule
`default_nettype wire

// File: tb/tb_neuron_potential_accumulator.sv
`default_nettype none
// ==================================================================
// tb_neuron_potential_accumulator : directed self-checking bench (mode 0 and mode 1 DUTs)
// Rev 1.0
// ==================================================================
module tb_neuron_potential_accumulator;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        clear;
  logic [15:0] v_threshold;
  logic        timestep_end;
  logic [1:0]  rd_id;
  logic        spike_valid0, spike_valid1, err_overrun0, err_overrun1;
  logic [3:0]  spike_vector0, spike_vector1;
  logic [15:0] rd_potential0, rd_potential1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  neuron_potential_accumulator_if #(.DATA_W(16), .ID_W(2)) ifc0 ();
  neuron_potential_accumulator_if #(.DATA_W(16), .ID_W(2)) ifc1 ();

  neuron_potential_accumulator #(.NUM_NEURONS(4), .DATA_W(16), .FRAC_W(8), .LEAK_SHIFT(2),
                                 .REFRACT_CYCLES(2), .RESET_MODE(0)) u_dut0 (
    .CLK(CLK), .RESETN(RESETN), .clear(clear), .v_threshold(v_threshold), .in_if(ifc0),
    .timestep_end(timestep_end), .spike_valid(spike_valid0), .spike_vector(spike_vector0),
    .err_overrun(err_overrun0), .rd_id(rd_id), .rd_potential(rd_potential0)
  );

  neuron_potential_accumulator #(.NUM_NEURONS(4), .DATA_W(16), .FRAC_W(8), .LEAK_SHIFT(2),
                                 .REFRACT_CYCLES(2), .RESET_MODE(1)) u_dut1 (
    .CLK(CLK), .RESETN(RESETN), .clear(clear), .v_threshold(v_threshold), .in_if(ifc1),
    .timestep_end(timestep_end), .spike_valid(spike_valid1), .spike_vector(spike_vector1),
    .err_overrun(err_overrun1), .rd_id(rd_id), .rd_potential(rd_potential1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] id, input logic [15:0] w);
    ifc0.in_valid = 1'b1; ifc0.in_neuron_id = id; ifc0.in_weight = w;
    ifc1.in_valid = 1'b1; ifc1.in_neuron_id = id; ifc1.in_weight = w;
    tick();
    ifc0.in_valid = 1'b0;
    ifc1.in_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] id, output logic [15:0] p0, output logic [15:0] p1);
    rd_id = id;
    #1;
    p0 = rd_potential0;
    p1 = rd_potential1;
  endtask

  // Full timestep: evaluation must take exactly NUM_NEURONS edges, then a one-cycle spike_valid.
  task automatic end_ts(input string tag, output logic [3:0] vec0, output logic [3:0] vec1);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    check({tag, "_rdy_in_eval"}, 32'(ifc0.in_ready), 32'd0);
    repeat (3) tick();
    check({tag, "_sv_early"}, 32'(spike_valid0), 32'd0);
    tick();
    check({tag, "_sv"}, 32'({spike_valid1, spike_valid0}), 32'h3);
    vec0 = spike_vector0;
    vec1 = spike_vector1;
    tick();
    check({tag, "_sv_pulse"}, 32'(spike_valid0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p0, p1;
    logic [3:0]  v0, v1;
    int          pulses;

    RESETN = 1'b0; clear = 1'b0; v_threshold = 16'h0A00; timestep_end = 1'b0; rd_id = 2'd0;
    ifc0.in_valid = 1'b0; ifc0.in_neuron_id = 2'd0; ifc0.in_weight = 16'h0;
    ifc1.in_valid = 1'b0; ifc1.in_neuron_id = 2'd0; ifc1.in_weight = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_outputs", {spike_valid0, err_overrun0, spike_vector0}, 32'h0);
    check("rst_ready", 32'(ifc0.in_ready), 32'd1);
    RESETN = 1'b1;
    tick();
    rd(2'd1, p0, p1);
    check("rst_pot1", 32'(p0), 32'h0);

    // Two weights summing to exactly the threshold fire neuron 1
    send(2'd1, 16'h0500);
    send(2'd1, 16'h0500);
    rd(2'd1, p0, p1);
    check("acc_pot1", 32'(p0), 32'h0A00);
    end_ts("ts_fire1", v0, v1);
    check("fire1_vec", 32'(v0), 32'b0010);
    rd(2'd1, p0, p1);
    check("fire1_pot", 32'(p0), 32'h0000);

    // Sub-threshold leak over two timesteps
    send(2'd0, 16'h0800);
    end_ts("ts_leak1", v0, v1);
    check("leak1_vec", 32'(v0), 32'b0000);
    rd(2'd0, p0, p1);
    check("leak1_pot", 32'(p0), 32'h0600);
    end_ts("ts_leak2", v0, v1);
    rd(2'd0, p0, p1);
    check("leak2_pot", 32'(p0), 32'h0480);

    // Positive and negative saturation, then mode-dependent reset
    send(2'd2, 16'h7000);
    send(2'd2, 16'h7000);
    send(2'd3, 16'h8000);
    send(2'd3, 16'h8000);
    rd(2'd2, p0, p1);
    check("sat_hi", {p1, p0}, 32'h7FFF_7FFF);
    rd(2'd3, p0, p1);
    check("sat_lo", 32'(p0), 32'h8000);
    end_ts("ts_sat", v0, v1);
    check("sat_vec", {v1, v0}, 32'h44);
    rd(2'd2, p0, p1);
    check("mode_reset", {p1, p0}, 32'h75FF_0000);
    rd(2'd3, p0, p1);
    check("neg_leak", 32'(p0), 32'hA000);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    rd(2'd2, p0, p1);
    check("clr_pot2", {p1, p0}, 32'h0);
    check("clr_vec", 32'(spike_vector0), 32'h0);

    // Refractory: neuron 3 driven at threshold every timestep
    for (int t = 1; t <= 4; t++) begin
      send(2'd3, 16'h0A00);
      if (t == 2) begin
        rd(2'd3, p0, p1);
        check("refr_discard", 32'(p0), 32'h0);
      end
      end_ts($sformatf("ts_refr%0d", t), v0, v1);
      check($sformatf("refr%0d_n3", t), 32'(v0[3]), (t == 1 || t == 4) ? 32'd1 : 32'd0);
    end

    // timestep_end during evaluation is flagged and ignored
    send(2'd0, 16'h0A00);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    check("ovr_pulse", 32'(err_overrun0), 32'd1);
    tick();
    check("ovr_clear", 32'(err_overrun0), 32'd0);
    tick();
    check("ovr_sv", {spike_valid0, spike_vector0}, 32'h11);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (spike_valid0) pulses++;
    end
    check("ovr_no_extra", 32'(pulses), 32'd0);

    // Asynchronous reset in the middle of an evaluation
    send(2'd2, 16'h0500);
    rd(2'd2, p0, p1);
    check("pre_rst_pot2", 32'(p0), 32'h0500);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    tick();
    RESETN = 1'b0;
    #1;
    check("arst_outputs", {spike_valid0, err_overrun0, spike_vector0}, 32'h0);
    check("arst_ready", 32'(ifc0.in_ready), 32'd1);
    rd(2'd2, p0, p1);
    check("arst_pot2", 32'(p0), 32'h0);
    tick();
    RESETN = 1'b1;
    tick();
    check("rel_ready", 32'(ifc0.in_ready), 32'd1);
    send(2'd2, 16'h0A00);
    end_ts("ts_post_rst", v0, v1);
    check("post_rst_vec", 32'(v0), 32'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
